// File: rtl/bcd_counter_pkg.sv
// Shared BCD types, digit limits and validity helper for the up/down counter.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_valid_bcd(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with its increment/decrement and carry/borrow logic.
module bcd_digit_cell
  import bcd_counter_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       carry_in,
  input  logic       borrow_in,
  output bcd_digit_t digit,
  output logic       carry_out,
  output logic       borrow_out
);

  // A digit only ripples onward when it rolls over, so carries chain within one cycle.
  assign carry_out  = carry_in  && (digit == BCD_MAX);
  assign borrow_out = borrow_in && (digit == BCD_MIN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= is_valid_bcd(load_digit) ? load_digit : BCD_MIN;
    end else if (carry_in) begin
      digit <= carry_out ? BCD_MIN : digit + 4'd1;
    end else if (borrow_in) begin
      digit <= borrow_out ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, wrap or saturate at the limits,
// and cascadable terminal output.
module bcd_updown_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                up_down,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                terminal,
  output logic                wrap,
  output logic                load_error
);

  logic [DIGITS:0] carry;
  logic [DIGITS:0] borrow;
  bcd_digit_t      digits [DIGITS];
  logic            at_max;
  logic            at_min;
  logic            load_bad;
  logic            step;
  logic            limit_cross;

  always_comb begin
    at_max   = 1'b1;
    at_min   = 1'b1;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      at_max   = at_max && (digits[i] == BCD_MAX);
      at_min   = at_min && (digits[i] == BCD_MIN);
      load_bad = load_bad || !is_valid_bcd(load_value[4*i +: 4]);
    end
  end

  assign terminal = enable && (up_down ? at_max : at_min);

  // In saturating mode the step is suppressed at the limit so the count holds.
  assign step      = enable && !(SATURATE && terminal);
  assign carry[0]  = step && up_down;
  assign borrow[0] = step && !up_down;

  // A rollover shows up as a carry/borrow leaving the top digit.
  assign limit_cross = SATURATE ? terminal : (carry[DIGITS] || borrow[DIGITS]);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load),
      .load_digit (load_value[4*i +: 4]),
      .carry_in   (carry[i]),
      .borrow_in  (borrow[i]),
      .digit      (digits[i]),
      .carry_out  (carry[i+1]),
      .borrow_out (borrow[i+1])
    );
    assign count[4*i +: 4] = digits[i];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrap       <= 1'b0;
      load_error <= 1'b0;
    end else begin
      wrap       <= !load && limit_cross;
      load_error <= load && load_bad;
    end
  end

endmodule
